reg_scoreboard: RTL and testbench

Decode-stage register interlock for the 5-stage pipeline. It tracks which architectural registers have writes in flight between issue and writeback, and detects load-use hazards that forwarding cannot cover. It raises the stall/bubble controls that hold fetch/decode and inject a NOP into decode/execute. It is the producer-side counterpart of the forwarding select logic: it decides when a consumer may issue, and forwarding decides where the operand comes from.

---
 rtl/sb_pkg.sv | 14 +
 rtl/sb_counter.sv | 50 +++++
 rtl/reg_scoreboard.sv | 100 ++++++++++
 tb/tb_reg_scoreboard.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared constants and the DE-stage shadow entry used by the register scoreboard.
// Register indices are 3 bits wide, and each per-register in-flight counter is 2 bits wide.
package sb_pkg;
  localparam int REG_W = 3;
  localparam int NREG  = 8;
  localparam int CNT_W = 2;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             wr;
    logic             ld;
  } de_entry_t;
endpackage

// File: rtl/sb_counter.sv
// In-flight write counter for one architectural register: one increment, two decrements.
// The counter saturates at both ends; reaching either end is illegal and is flagged by an assertion.
module sb_counter
  import sb_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic inc_i,
  input  logic dec_a_i,
  input  logic dec_b_i,
  output logic busy_o
);

  logic [W-1:0]        cnt_q, cnt_d;
  logic signed [W+1:0] sum;
  logic                ovf, unf;

  // The net change lies in -2..+1, so two guard bits expose both overflow and underflow.
  always_comb begin
    sum = $signed({2'b00, cnt_q})
        + $signed({{(W+1){1'b0}}, inc_i})
        - $signed({{(W+1){1'b0}}, dec_a_i})
        - $signed({{(W+1){1'b0}}, dec_b_i});
    unf = sum[W+1];
    ovf = ~sum[W+1] & sum[W];
    if (unf) begin
      cnt_d = '0;
    end else if (ovf) begin
      cnt_d = '1;
    end else begin
      cnt_d = sum[W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

  a_no_wrap : assert property (@(posedge clk_i) disable iff (rst_i) en_i |-> !(ovf || unf));

endmodule

// File: rtl/reg_scoreboard.sv
// Decode-stage register interlock: in-flight write tracking, load-use stall/bubble and issue control.
// Optional macro STALL_COUNT_EN adds a 16-bit load-use stall cycle counter output.
module reg_scoreboard
  import sb_pkg::*;
#(
  parameter int NREG = sb_pkg::NREG,
  parameter int CNT_W = sb_pkg::CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_rs_v_i,
  input  logic             id_rt_v_i,
  input  logic [REG_W-1:0] id_rd_i,
  input  logic             id_reg_write_i,
  input  logic             id_mem_read_i,
  input  logic             mem_stall_i,
  input  logic             flush_i,
  input  logic             wb_valid_i,
  input  logic             wb_reg_write_i,
  input  logic [REG_W-1:0] wb_rd_i,
`ifdef STALL_COUNT_EN
  output logic [15:0]      stall_cycles_o,
`endif
  output logic             stall_fd_o,
  output logic             bubble_de_o,
  output logic             issue_o,
  output logic [NREG-1:0]  busy_mask_o
);

  de_entry_t de_q, de_d;
  logic      load_use;
  logic      wb_dec;
  logic      flush_dec;

  always_comb begin
    load_use = de_q.v & de_q.ld & de_q.wr & id_valid_i &
               ((id_rs_v_i & (id_rs_i == de_q.rd)) | (id_rt_v_i & (id_rt_i == de_q.rd)));
    stall_fd_o  = mem_stall_i | load_use;
    bubble_de_o = load_use & ~mem_stall_i & ~flush_i;
    issue_o     = id_valid_i & ~stall_fd_o & ~flush_i;
    wb_dec      = wb_valid_i & wb_reg_write_i;
    flush_dec   = flush_i & de_q.v & de_q.wr;
  end

  // A stalled or flushed cycle leaves an empty slot in DE.
  always_comb begin
    de_d = '0;
    if (issue_o) begin
      de_d.v  = 1'b1;
      de_d.rd = id_rd_i;
      de_d.wr = id_reg_write_i;
      de_d.ld = id_mem_read_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      de_q <= '0;
    end else if (!mem_stall_i) begin
      de_q <= de_d;
    end
  end

  for (genvar i = 0; i < NREG; i++) begin : g_cnt
    sb_counter #(.W(CNT_W)) u_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (~mem_stall_i),
      .inc_i   (issue_o & id_reg_write_i & (id_rd_i == REG_W'(i))),
      .dec_a_i (wb_dec & (wb_rd_i == REG_W'(i))),
      .dec_b_i (flush_dec & (de_q.rd == REG_W'(i))),
      .busy_o  (busy_mask_o[i])
    );
  end

`ifdef STALL_COUNT_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (load_use && !mem_stall_i) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: hazards, flush rollback, mem_stall freeze and mid-stream reset.
module tb_reg_scoreboard;
  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs_v, id_rt_v, id_reg_write, id_mem_read;
  logic [2:0] id_rs, id_rt, id_rd, wb_rd;
  logic       mem_stall, flush, wb_valid, wb_reg_write;
  logic       stall_fd, bubble_de, issue;
  logic [7:0] busy_mask;
`ifdef STALL_COUNT_EN
  logic [15:0] stall_cycles;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  reg_scoreboard dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .id_valid_i     (id_valid),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_rs_v_i      (id_rs_v),
    .id_rt_v_i      (id_rt_v),
    .id_rd_i        (id_rd),
    .id_reg_write_i (id_reg_write),
    .id_mem_read_i  (id_mem_read),
    .mem_stall_i    (mem_stall),
    .flush_i        (flush),
    .wb_valid_i     (wb_valid),
    .wb_reg_write_i (wb_reg_write),
    .wb_rd_i        (wb_rd),
`ifdef STALL_COUNT_EN
    .stall_cycles_o (stall_cycles),
`endif
    .stall_fd_o     (stall_fd),
    .bubble_de_o    (bubble_de),
    .issue_o        (issue),
    .busy_mask_o    (busy_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_id();
    id_valid = 0; id_rs_v = 0; id_rt_v = 0; id_rs = 0; id_rt = 0;
    id_rd = 0; id_reg_write = 0; id_mem_read = 0;
  endtask

  task automatic set_id(input logic [2:0] rd, input logic wr, input logic ld,
                        input logic [2:0] rs, input logic rs_v);
    id_valid = 1; id_rd = rd; id_reg_write = wr; id_mem_read = ld;
    id_rs = rs; id_rs_v = rs_v; id_rt = 0; id_rt_v = 0;
  endtask

  task automatic set_wb(input logic v, input logic [2:0] rd);
    wb_valid = v; wb_reg_write = v; wb_rd = rd;
  endtask

  initial begin
    rst = 1; mem_stall = 0; flush = 0;
    idle_id();
    set_wb(0, 0);
    tick(); tick();

    // Reset state: decode holds a non-writing instruction.
    rst = 0;
    set_id(0, 0, 0, 0, 0);
    #1;
    chk("rst_stall", {31'd0, stall_fd}, 0);
    chk("rst_bubble", {31'd0, bubble_de}, 0);
    chk("rst_issue", {31'd0, issue}, 1);
    chk("rst_busy", {24'd0, busy_mask}, 0);
    tick();

    // ADD r3, then writeback four cycles later.
    set_id(3, 1, 0, 0, 0);
    #1 chk("add_issue", {31'd0, issue}, 1);
    tick();
    idle_id();
    chk("add_busy", {24'd0, busy_mask}, 32'h08);
    tick(); tick(); tick();
    chk("add_busy_hold", {24'd0, busy_mask}, 32'h08);
    set_wb(1, 3);
    tick();
    set_wb(0, 0);
    chk("add_wb_clear", {24'd0, busy_mask}, 0);

    // Load r2 followed by an ADD r6 reading r2.
    set_id(2, 1, 1, 0, 0);
    tick();
    set_id(6, 1, 0, 2, 1);
    #1;
    chk("lu_stall", {31'd0, stall_fd}, 1);
    chk("lu_bubble", {31'd0, bubble_de}, 1);
    chk("lu_issue", {31'd0, issue}, 0);
    chk("lu_busy", {24'd0, busy_mask}, 32'h04);
    tick();
    chk("lu2_stall", {31'd0, stall_fd}, 0);
    chk("lu2_bubble", {31'd0, bubble_de}, 0);
    chk("lu2_issue", {31'd0, issue}, 1);
    tick();
    idle_id();
    chk("lu_busy2", {24'd0, busy_mask}, 32'h44);
`ifdef STALL_COUNT_EN
    chk("lu_stall_cycles", {16'd0, stall_cycles}, 1);
`endif
    set_wb(1, 2); tick();
    set_wb(1, 6); tick();
    set_wb(0, 0);
    chk("lu_wb_clear", {24'd0, busy_mask}, 0);

    // Load r2, consumer names r2 but does not read it.
    set_id(2, 1, 1, 0, 0);
    tick();
    set_id(0, 0, 0, 2, 0);
    id_rt = 2;
    #1;
    chk("noread_stall", {31'd0, stall_fd}, 0);
    chk("noread_issue", {31'd0, issue}, 1);
    tick();
    idle_id();
    set_wb(1, 2); tick();
    set_wb(0, 0);
    chk("noread_clear", {24'd0, busy_mask}, 0);

    // Issue r5 write, then flush with a writer of r7 in decode.
    set_id(5, 1, 0, 0, 0);
    tick();
    set_id(7, 1, 0, 0, 0);
    flush = 1;
    #1;
    chk("fl_issue", {31'd0, issue}, 0);
    chk("fl_bubble", {31'd0, bubble_de}, 0);
    chk("fl_busy_pre", {24'd0, busy_mask}, 32'h20);
    tick();
    flush = 0;
    idle_id();
    chk("fl_busy_post", {24'd0, busy_mask}, 0);

    // Same-cycle issue and writeback on r4 while cnt[4]=1.
    set_id(4, 1, 0, 0, 0);
    tick();
    chk("r4_busy", {24'd0, busy_mask}, 32'h10);
    set_wb(1, 4);
    tick();
    idle_id();
    chk("r4_same_cycle", {24'd0, busy_mask}, 32'h10);
    mem_stall = 1;
    set_id(1, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("ms_stall", {31'd0, stall_fd}, 1);
      chk("ms_issue", {31'd0, issue}, 0);
      tick();
      chk("ms_busy", {24'd0, busy_mask}, 32'h10);
    end
    mem_stall = 0;
    idle_id();
    tick();
    set_wb(0, 0);
    chk("r4_last_wb", {24'd0, busy_mask}, 0);

    // Build cnt[1]=2 with a load of r3 in DE, then reset mid-stream.
    set_id(1, 1, 0, 0, 0); tick();
    set_id(1, 1, 0, 0, 0); tick();
    set_id(3, 1, 1, 0, 0); tick();
    set_id(0, 0, 0, 3, 1);
    #1;
    chk("pre_rst_stall", {31'd0, stall_fd}, 1);
    chk("pre_rst_busy", {24'd0, busy_mask}, 32'h0A);
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("mid_rst_busy", {24'd0, busy_mask}, 0);
    chk("mid_rst_stall", {31'd0, stall_fd}, 0);
    chk("mid_rst_bubble", {31'd0, bubble_de}, 0);
    chk("mid_rst_issue", {31'd0, issue}, 1);
`ifdef STALL_COUNT_EN
    chk("mid_rst_stall_cycles", {16'd0, stall_cycles}, 0);
`endif
    idle_id();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
